// File: rtl/serial_ck_pkg.sv
// Shared types, default widths and flat-array indexing helper for the
// serial_ck_gen waveform generator.
package serial_ck_pkg;

   typedef enum logic {
      IDLE = 1'b0,
      RUN  = 1'b1
   } state_t;

   localparam int unsigned DEF_NCH   = 2;
   localparam int unsigned DEF_NEDGE = 4;
   localparam int unsigned DEF_CW    = 16;
   localparam int unsigned DEF_NW    = 8;

   // LSB of entry k of channel c inside a flat edge_pos vector
   function automatic int unsigned edge_lsb(input int unsigned c,
                                            input int unsigned k,
                                            input int unsigned nedge,
                                            input int unsigned cw);
      return (c * nedge + k) * cw;
   endfunction

endpackage

// File: rtl/serial_ck_edge_par.sv
// Parity of enabled edge positions of one channel that match the given phase.
module serial_ck_edge_par
   import serial_ck_pkg::*;
#(
   parameter int unsigned NEDGE = DEF_NEDGE,
   parameter int unsigned CW    = DEF_CW
) (
   input  logic [NEDGE*CW-1:0] pos,
   input  logic [NEDGE-1:0]    en,
   input  logic [CW-1:0]       phase,
   output logic                par
);

   always_comb begin
      par = 1'b0;
      for (int unsigned k = 0; k < NEDGE; k++) begin
         par = par ^ (en[k] && (pos[edge_lsb(0, k, NEDGE, CW) +: CW] == phase));
      end
   end

endmodule

// File: rtl/serial_ck_gen.sv
// Multi-channel serial waveform generator: one shared phase counter, per-channel
// programmable toggle positions, finite or continuous runs with start/stop/ack.
module serial_ck_gen
   import serial_ck_pkg::*;
#(
   parameter int unsigned NCH   = DEF_NCH,
   parameter int unsigned NEDGE = DEF_NEDGE,
   parameter int unsigned CW    = DEF_CW,
   parameter int unsigned NW    = DEF_NW
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    start,
   input  logic                    stop,
   input  logic [CW-1:0]           period,
   input  logic [NW-1:0]           ncyc,
   input  logic [NCH-1:0]          y0,
   input  logic [NCH*NEDGE*CW-1:0] edge_pos,
   input  logic [NCH*NEDGE-1:0]    edge_en,
   output logic [NCH-1:0]          y,
   output logic                    busy,
   output logic                    ack,
   output logic                    err
);

   state_t                  state_q, state_d;
   logic [CW-1:0]           phase_q, phase_d, period_q, period_d;
   logic [NW-1:0]           cycle_q, cycle_d, ncyc_q, ncyc_d;
   logic [NCH-1:0]          y0_q, y0_d, y_q, y_d;
   logic [NCH*NEDGE*CW-1:0] pos_q, pos_d;
   logic [NCH*NEDGE-1:0]    en_q, en_d;
   logic                    ack_q, ack_d, err_q, err_d;

   logic                    wrap, done, launch;
   logic [CW-1:0]           phase_nx, par_phase;
   logic [NCH*NEDGE*CW-1:0] par_pos;
   logic [NCH*NEDGE-1:0]    par_en;
   logic [NCH-1:0]          par;

   // Parity is evaluated one phase ahead so a toggle at p shows up during phase p;
   // in IDLE the live config is used to produce the phase-0 level at launch.
   always_comb begin
      wrap      = (phase_q == period_q - CW'(1));
      phase_nx  = wrap ? '0 : phase_q + CW'(1);
      done      = wrap && (ncyc_q != '0) && (cycle_q == ncyc_q - NW'(1));
      launch    = (state_q == IDLE) && start && (period != '0);
      par_phase = (state_q == IDLE) ? '0 : phase_nx;
      par_pos   = (state_q == IDLE) ? edge_pos : pos_q;
      par_en    = (state_q == IDLE) ? edge_en : en_q;
   end

   for (genvar c = 0; c < NCH; c++) begin : g_ch
      serial_ck_edge_par #(
         .NEDGE (NEDGE),
         .CW    (CW)
      ) u_par (
         .pos   (par_pos[c*NEDGE*CW +: NEDGE*CW]),
         .en    (par_en[c*NEDGE +: NEDGE]),
         .phase (par_phase),
         .par   (par[c])
      );
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         phase_q  <= '0;
         cycle_q  <= '0;
         period_q <= '0;
         ncyc_q   <= '0;
         y0_q     <= '0;
         pos_q    <= '0;
         en_q     <= '0;
         y_q      <= '0;
         ack_q    <= 1'b0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         phase_q  <= phase_d;
         cycle_q  <= cycle_d;
         period_q <= period_d;
         ncyc_q   <= ncyc_d;
         y0_q     <= y0_d;
         pos_q    <= pos_d;
         en_q     <= en_d;
         y_q      <= y_d;
         ack_q    <= ack_d;
         err_q    <= err_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (launch) state_d = RUN;
         RUN:     if (stop || done) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      phase_d  = phase_q;
      cycle_d  = cycle_q;
      period_d = period_q;
      ncyc_d   = ncyc_q;
      y0_d     = y0_q;
      pos_d    = pos_q;
      en_d     = en_q;
      y_d      = y_q;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (start && (period == '0)) begin
               err_d = 1'b1;
            end else if (launch) begin
               period_d = period;
               ncyc_d   = ncyc;
               y0_d     = y0;
               pos_d    = edge_pos;
               en_d     = edge_en;
               phase_d  = '0;
               cycle_d  = '0;
               y_d      = y0 ^ par;
            end
         end
         RUN: begin
            // stop and completion collapse into the same single exit
            if (stop || done) begin
               ack_d = 1'b1;
               y_d   = y0_q;
            end else begin
               phase_d = phase_nx;
               if (wrap) cycle_d = cycle_q + NW'(1);
               y_d = y_q ^ par;
            end
         end
         default: ;
      endcase
   end

   assign y    = y_q;
   assign busy = (state_q == RUN);
   assign ack  = ack_q;
   assign err  = err_q;

endmodule

// File: tb/tb_serial_ck_gen.sv
// Self-checking bench for serial_ck_gen: table-driven runs against a closed-form
// waveform model, plus hand-written corner sequences, checked via a scoreboard.
module tb_serial_ck_gen;

   logic         clk, rst, start, stop;
   logic [15:0]  period;
   logic [7:0]   ncyc;
   logic [1:0]   y0, y;
   logic [127:0] edge_pos;
   logic [7:0]   edge_en;
   logic         busy, ack, err;

   typedef struct {
      logic [15:0]  period;
      logic [7:0]   ncyc;
      logic [1:0]   y0;
      logic [127:0] pos;
      logic [7:0]   en;
      int unsigned  stop_at;
      string        name;
   } vec_t;

   typedef struct {
      logic [1:0] y;
      logic       busy;
      logic       ack;
      logic       err;
      string      tag;
   } exp_t;

   exp_t sb[$];
   vec_t tbl[4];
   int   checks   = 0;
   int   failures = 0;
   bit   base_y[8] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};

   serial_ck_gen #(
      .NCH   (2),
      .NEDGE (4),
      .CW    (16),
      .NW    (8)
   ) dut (
      .clk      (clk),
      .rst      (rst),
      .start    (start),
      .stop     (stop),
      .period   (period),
      .ncyc     (ncyc),
      .y0       (y0),
      .edge_pos (edge_pos),
      .edge_en  (edge_en),
      .y        (y),
      .busy     (busy),
      .ack      (ack),
      .err      (err)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: run did not finish, checks=%0d", checks);
      $fatal(1);
   end

   task automatic chk(input string n, input logic [31:0] act, input logic [31:0] xp);
      checks++;
      if (act !== xp) begin
         failures++;
         $display("FAIL %s: got=%0h expected=%0h", n, act, xp);
      end
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (sb.size() != 0) begin
         e = sb.pop_front();
         chk({e.tag, ".y"},    32'(y),    32'(e.y));
         chk({e.tag, ".busy"}, 32'(busy), 32'(e.busy));
         chk({e.tag, ".ack"},  32'(ack),  32'(e.ack));
         chk({e.tag, ".err"},  32'(err),  32'(e.err));
      end
   end

   task automatic push(input logic [1:0] ey, input logic eb, input logic ea,
                       input logic ee, input string tag);
      exp_t e;
      e.y = ey; e.busy = eb; e.ack = ea; e.err = ee; e.tag = tag;
      sb.push_back(e);
   endtask

   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      #1;
   endtask

   // Closed form: level = y0 ^ parity(toggles at or before phase + cycles * toggles per period)
   function automatic logic [1:0] model(input vec_t v, input int unsigned idx);
      logic [1:0]  r;
      logic [15:0] p;
      int unsigned per, ph, cyc, cnt, tot;
      per = 32'(v.period);
      ph  = idx % per;
      cyc = idx / per;
      for (int unsigned c = 0; c < 2; c++) begin
         cnt = 0;
         tot = 0;
         for (int unsigned k = 0; k < 4; k++) begin
            p = v.pos[(c*4+k)*16 +: 16];
            if (v.en[c*4+k] && (32'(p) < per)) begin
               tot++;
               if (32'(p) <= ph) cnt++;
            end
         end
         r[c] = v.y0[c] ^ (((cnt + cyc * tot) % 2) == 1);
      end
      return r;
   endfunction

   function automatic logic [127:0] pos8(input logic [15:0] a0, a1, a2, a3,
                                         input logic [15:0] a4, a5, a6, a7);
      return {a7, a6, a5, a4, a3, a2, a1, a0};
   endfunction

   function automatic vec_t mk(input logic [15:0] per, input logic [7:0] nc,
                               input logic [1:0] iy0, input logic [127:0] p,
                               input logic [7:0] en, input int unsigned st,
                               input string nm);
      vec_t v;
      v.period = per; v.ncyc = nc; v.y0 = iy0; v.pos = p; v.en = en;
      v.stop_at = st; v.name = nm;
      return v;
   endfunction

   task automatic drive_cfg(input vec_t v);
      period   = v.period;
      ncyc     = v.ncyc;
      y0       = v.y0;
      edge_pos = v.pos;
      edge_en  = v.en;
   endtask

   task automatic scramble();
      period   = 16'($urandom);
      ncyc     = 8'($urandom);
      y0       = 2'($urandom);
      edge_pos = {4{$urandom}};
      edge_en  = 8'($urandom);
   endtask

   task automatic run_case(input vec_t v);
      int unsigned len;
      len = (v.stop_at != 0) ? v.stop_at : 32'(v.period) * 32'(v.ncyc);
      drive_cfg(v);
      start = 1'b1;
      push(model(v, 0), 1'b1, 1'b0, 1'b0, $sformatf("%s[0]", v.name));
      tick();
      start = 1'b0;
      scramble();
      for (int unsigned j = 1; j < len; j++) begin
         push(model(v, j), 1'b1, 1'b0, 1'b0, $sformatf("%s[%0d]", v.name, j));
         tick();
      end
      if (v.stop_at != 0) stop = 1'b1;
      push(v.y0, 1'b0, 1'b1, 1'b0, {v.name, ".ack"});
      tick();
      stop = 1'b0;
      push(v.y0, 1'b0, 1'b0, 1'b0, {v.name, ".after"});
      tick();
   endtask

   task automatic run_base(input int unsigned cut);
      vec_t v;
      v = mk(16'd8, 8'd2, 2'b01, pos8(16'd2, 16'd3, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0),
             8'b0000_0011, 0, "base");
      drive_cfg(v);
      start = 1'b1;
      for (int unsigned j = 0; j < 16 && j < cut; j++) begin
         push({1'b0, base_y[j % 8]}, 1'b1, 1'b0, 1'b0, $sformatf("base[%0d]", j));
         tick();
         start = 1'b0;
      end
      if (cut >= 16) begin
         push(2'b01, 1'b0, 1'b1, 1'b0, "base.ack");
         tick();
         push(2'b01, 1'b0, 1'b0, 1'b0, "base.after");
         tick();
      end
   endtask

   initial begin
      vec_t b2b;
      rst = 1'b1; start = 1'b0; stop = 1'b0;
      period = '0; ncyc = '0; y0 = '0; edge_pos = '0; edge_en = '0;
      #1;
      chk("reset.y", 32'(y), 32'h0);
      chk("reset.busy", 32'(busy), 32'h0);
      chk("reset.ack", 32'(ack), 32'h0);
      chk("reset.err", 32'(err), 32'h0);
      @(negedge clk); #1;
      rst = 1'b0;
      push(2'b00, 1'b0, 1'b0, 1'b0, "idle0");
      tick();

      run_base(16);

      tbl[0] = mk(16'd4, 8'd0, 2'b00,
                  pos8(16'd0, 16'd2, 16'd0, 16'd0, 16'd1, 16'd0, 16'd0, 16'd0),
                  8'b0001_0011, 14, "cont2");
      tbl[1] = mk(16'd4, 8'd1, 2'b10,
                  pos8(16'd4, 16'd1, 16'd1, 16'd0, 16'hFFFF, 16'd0, 16'd0, 16'd0),
                  8'b0001_0111, 0, "bound");
      tbl[2] = mk(16'd3, 8'd2, 2'b01,
                  pos8(16'd0, 16'd0, 16'd0, 16'd0, 16'd2, 16'd0, 16'd0, 16'd0),
                  8'b0001_0001, 6, "stopdone");
      tbl[3] = mk(16'd5, 8'd3, 2'b11,
                  pos8(16'd1, 16'd3, 16'd4, 16'd0, 16'd0, 16'd2, 16'd7, 16'd5),
                  8'b1111_1111, 0, "mixed");
      for (int unsigned i = 0; i < 4; i++) run_case(tbl[i]);

      // back-to-back: start held through ack
      b2b = mk(16'd3, 8'd1, 2'b01,
               pos8(16'd1, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0),
               8'b0000_0001, 0, "b2b");
      drive_cfg(b2b);
      start = 1'b1;
      for (int unsigned j = 0; j < 3; j++) begin
         push(model(b2b, j), 1'b1, 1'b0, 1'b0, $sformatf("b2b.r1[%0d]", j));
         tick();
      end
      push(2'b01, 1'b0, 1'b1, 1'b0, "b2b.ack1");
      tick();
      push(model(b2b, 0), 1'b1, 1'b0, 1'b0, "b2b.r2[0]");
      tick();
      start = 1'b0;
      for (int unsigned j = 1; j < 3; j++) begin
         push(model(b2b, j), 1'b1, 1'b0, 1'b0, $sformatf("b2b.r2[%0d]", j));
         tick();
      end
      push(2'b01, 1'b0, 1'b1, 1'b0, "b2b.ack2");
      tick();

      // period==0 start, then stop while idle
      period = '0;
      start  = 1'b1;
      push(2'b01, 1'b0, 1'b0, 1'b1, "err.pulse");
      tick();
      start = 1'b0;
      stop  = 1'b1;
      push(2'b01, 1'b0, 1'b0, 1'b0, "err.after");
      tick();
      stop = 1'b0;

      // async reset mid-run, asserted away from the active edge
      run_base(5);
      rst = 1'b1;
      #1;
      chk("areset.y", 32'(y), 32'h0);
      chk("areset.busy", 32'(busy), 32'h0);
      chk("areset.ack", 32'(ack), 32'h0);
      push(2'b00, 1'b0, 1'b0, 1'b0, "areset.hold");
      tick();
      rst = 1'b0;
      push(2'b00, 1'b0, 1'b0, 1'b0, "areset.noack");
      tick();
      run_base(16);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/serial_ck_gen.md
# serial_ck_gen

Parametrised multi-channel serial waveform generator. It is the successor to `serial_ck`. It drives `NCH` independent outputs from one internal phase counter. Each channel toggles at up to `NEDGE` programmable positions within a programmable period, repeated `ncyc` times or continuously until stopped. It sits between a register/config block and the serial pins (clock/strobe/data-framing lines). It replaces the external-counter scheme with an internal counter and adds a start/stop/ack handshake.

## Interface
- `NCH`, 2: number of output channels.
- `NEDGE`, 4: toggle positions per channel per period.
- `CW`, 16: width of period and edge positions.
- `NW`, 8: width of repeat count.
- `clk` input 1: sole clock, rising edge.
- `rst` input 1: asynchronous, active-high reset.
- `start` input 1: begin a run; sampled only in IDLE.
- `stop` input 1: abort a run; sampled only in RUN.
- `period` input CW: phases per cycle; legal range 1..2^CW-1.
- `ncyc` input NW: number of cycles; 0 means run until `stop`.
- `y0` input NCH: idle/start level per channel.
- `edge_pos` input NCH*NEDGE*CW: flat array; entry k of channel c is at bits [(c*NEDGE+k)*CW +: CW].
- `edge_en` input NCH*NEDGE: enable per entry, same index.
- `y` output NCH: registered waveform outputs.
- `busy` output 1: high in RUN.
- `ack` output 1: one-cycle pulse on completion or abort.
- `err` output 1: one-cycle pulse when `start` arrives with `period`==0.

## Operation
- States: IDLE, RUN.
- Reset values: `y`=0, `busy`=0, `ack`=0, `err`=0, phase=0, cycle=0, state=IDLE.
- **IDLE, start=1, period≠0**:
  - Latch `period`, `ncyc`, `y0`, `edge_pos`, `edge_en`.
  - Set phase=0, cycle=0, go to RUN.
  - Set `y` = y0 ^ par(0).
  - par(p)[c] is the XOR of `edge_en` over channel c's entries whose position equals p.
- **IDLE, start=1, period==0**: pulse `err`, stay in IDLE, leave `y` unchanged.
- **RUN, each cycle, stop=0**:
  - If phase==period-1: next phase=0 and cycle increments. Otherwise next phase=phase+1.
  - If phase==period-1 and (ncyc≠0 and cycle==ncyc-1), the run is finished: go to IDLE, pulse `ack`, set `y`=latched y0.
  - Otherwise set `y` = y ^ par(next phase).
- **RUN, stop=1**: go to IDLE, pulse `ack`, set `y`=latched y0. `stop` takes priority over normal completion in the same cycle; only one `ack` is issued.
- Edge positions ≥ period never fire.
- Duplicate enabled positions on one channel cancel pairwise (parity rule).
- `start` in RUN is ignored. `stop` in IDLE is ignored.
- Config inputs may change freely during RUN; only the latched copies are used.
- Cycle counter is NW bits. With ncyc=0 it wraps silently and the run continues.
- Phase and cycle arithmetic is unsigned, modulo 2^CW and 2^NW.

## Timing
- `start` sampled at edge T: `busy`=1 and phase 0 are visible in cycle T+1.
- A toggle at position p is visible in `y` during phase p of each cycle (lookahead compare).
- A finite run occupies period*ncyc cycles: T+1 .. T+period*ncyc.
- `ack`=1, `busy`=0 and `y`=y0 are visible in cycle T+period*ncyc+1.
- `stop` sampled at edge S: `ack`, `busy`=0 and `y`=y0 are visible in cycle S+1.
- A new `start` is accepted in the same cycle that `ack` is high (back-to-back runs, no gap).
- Reset mid-run: all outputs go to reset values immediately, asynchronously, with no `ack`.

## Structure
- Package `serial_ck_pkg`: state enum (IDLE, RUN), default widths, and a function to extract the flat `edge_pos` entry.
- Sub-module `serial_ck_edge_par`, one instance per channel: combinational parity of matches of `NEDGE` positions against a CW-bit phase.
- The top level holds the FSM, counters and output registers. Target is about 200 lines.

## Test plan
- **Single-channel baseline**: NCH=1, period=8, ncyc=2, y0=1, edges ch0 {2,3} enabled.
  - `y` = 1,1,0,1,1,1,1,1 repeated twice, T+1..T+16.
  - `ack` at T+17; `y`=1 afterwards.
- **Two channels, continuous**: period=4, ncyc=0, ch0 edges {0,2}, ch1 edge {1}, y0=00.
  - ch0 reads 1,1,0,0 repeating; ch1 toggles every 4 cycles.
  - `stop` at phase 1 of cycle 3 → `ack` and y=00 next cycle.
- **Boundary positions**: period=4, edge at 4 and duplicate edges at 1,1 → no toggles at all. `err` pulse for period=0, with `busy` staying 0.
- **Back-to-back**: `start` held high through `ack` → second run begins the cycle after `ack`, with period count exact; no idle phase inserted.
- **Simultaneous stop and completion** on the final phase → exactly one `ack`; y=y0.
- **Async reset** asserted mid-run, away from a clock edge → y=0 and busy=0 immediately, with no `ack`. A new `start` after reset behaves as in the baseline.
